demux_stream_n: RTL and testbench

- Parametrised, registered 1:N stream demultiplexer; successor to the team's 2-bit-select 1:4 combinational demux.
- Routes a W-bit data word with valid/ready handshake to one of N output channels, or broadcasts to all of them.
- Each output channel has a one-entry output register, so downstream back-pressure is per channel.
- Sits between a single producer and N independent consumers, e.g. a command router feeding per-lane engines.

---
 rtl/demux_stream_n.sv | 74 +++++++
 tb/tb_demux_stream_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n.sv
// Registered 1:N stream demultiplexer with per-channel one-entry output registers.
// Unicast by full-compare select, all-or-nothing broadcast, sticky flag for out-of-range selects.
module demux_stream_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_bcast,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic            err_sel,
  output logic            busy
);

  logic [N-1:0] hit;
  logic [N-1:0] free;
  logic [N-1:0] load;
  logic         sel_in_range;
  logic         uni_ready;
  logic         accept;
  logic         err_sel_reg;

  // A channel draining this cycle can be refilled on the same edge.
  assign sel_in_range = |hit;
  assign uni_ready    = sel_in_range ? |(hit & free) : 1'b1;
  assign in_ready     = in_bcast ? &free : uni_ready;
  assign accept       = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic         valid_reg;
      logic [W-1:0] data_reg;

      assign hit[gi]  = (in_sel == SW'(gi));
      assign free[gi] = ~valid_reg | out_ready[gi];
      assign load[gi] = accept & (in_bcast | hit[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (load[gi]) begin
          valid_reg <= 1'b1;
          data_reg  <= in_data;
        end else if (out_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign out_valid[gi]         = valid_reg;
      assign out_data[gi*W +: W]   = data_reg;
    end
  endgenerate

  // Out-of-range unicast words are accepted and dropped; remember that it happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel_reg <= 1'b0;
    end else if (accept & ~in_bcast & ~sel_in_range) begin
      err_sel_reg <= 1'b1;
    end
  end

  assign err_sel = err_sel_reg;
  assign busy    = |out_valid;

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: vector table, hand-written corner sequences and a
// randomized stream checked against a per-lane queue scoreboard.
module tb_demux_stream_n;

  logic        clk;
  logic        rst;

  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;
  logic        busy;

  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_bcast3;
  logic        in_valid3;
  logic        in_ready3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        err_sel3;
  logic        busy3;

  int checks   = 0;
  int failures = 0;

  demux_stream_n #(.N(4), .W(8), .SW(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel), .busy(busy)
  );

  demux_stream_n #(.N(3), .W(8), .SW(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_sel(err_sel3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic        bcast;
    logic        valid;
    logic [3:0]  rdy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  logic [7:0] q [4][$];
  logic       exp_rdy;
  int         sent;
  int         cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Unicasts, back-pressure with same-edge refill, blocked then accepted broadcast.
    tbl[0]  = '{2'd0, 8'hA0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h000000A0};
    tbl[1]  = '{2'd1, 8'hA1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000A1A0};
    tbl[2]  = '{2'd2, 8'hA2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A2A1A0};
    tbl[3]  = '{2'd3, 8'hA3, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'hA3A2A1A0};
    tbl[4]  = '{2'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'hA3A2A1A0};
    tbl[5]  = '{2'd2, 8'h11, 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0100, 32'hA311A1A0};
    tbl[6]  = '{2'd2, 8'h22, 1'b0, 1'b1, 4'b1011, 1'b0, 4'b0100, 32'hA311A1A0};
    tbl[7]  = '{2'd2, 8'h22, 1'b0, 1'b1, 4'b1011, 1'b0, 4'b0100, 32'hA311A1A0};
    tbl[8]  = '{2'd2, 8'h22, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'hA322A1A0};
    tbl[9]  = '{2'd2, 8'h00, 1'b0, 1'b0, 4'b1011, 1'b0, 4'b0100, 32'hA322A1A0};
    tbl[10] = '{2'd0, 8'h5A, 1'b1, 1'b1, 4'b1011, 1'b0, 4'b0100, 32'hA322A1A0};
    tbl[11] = '{2'd0, 8'h5A, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 32'h5A5A5A5A};
    tbl[12] = '{2'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h5A5A5A5A};

    rst = 1'b1;
    in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = '0;
    in_data3 = '0; in_sel3 = '0; in_bcast3 = 1'b0; in_valid3 = 1'b0; out_ready3 = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_err_sel", err_sel, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err_sel_n3", err_sel3, 0);

    for (int i = 0; i < NV; i++) begin
      in_sel = tbl[i].sel; in_data = tbl[i].data; in_bcast = tbl[i].bcast;
      in_valid = tbl[i].valid; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("vec%0d_busy", i), busy, |tbl[i].exp_valid);
      chk($sformatf("vec%0d_err_sel", i), err_sel, 0);
    end

    // Out-of-range select on the 3-channel instance.
    in_sel3 = 2'd2; in_data3 = 8'h77; in_valid3 = 1'b1; out_ready3 = 3'b000;
    #1;
    chk("n3_inrange_ready", in_ready3, 1);
    tick();
    chk("n3_inrange_valid", out_valid3, 3'b100);
    chk("n3_inrange_err", err_sel3, 0);
    in_sel3 = 2'd3; in_data3 = 8'hFF;
    #1;
    chk("n3_oor_ready", in_ready3, 1);
    tick();
    chk("n3_oor_valid", out_valid3, 3'b100);
    chk("n3_oor_data", out_data3, 24'h770000);
    chk("n3_oor_err", err_sel3, 1);
    in_valid3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("n3_err_hold%0d", i), err_sel3, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("n3_rst_err", err_sel3, 0);
    chk("n3_rst_valid", out_valid3, 0);
    #2 rst = 1'b0;

    // Async reset between edges with lanes 0 and 3 holding words.
    tick();
    in_sel = 2'd0; in_data = 8'h10; in_bcast = 1'b0; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    in_sel = 2'd3; in_data = 8'h13;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 4'b1001);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_busy", busy, 0);
    #2 rst = 1'b0;
    tick();
    in_sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1; out_ready = 4'b1111;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 4'b0010);
    chk("post_rst_data", out_data, 32'h00003C00);
    tick();
    chk("post_rst_drained", busy, 0);

    // Random unicast stream against per-lane queues.
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 2000) begin
      cyc++;
      in_sel = 2'($urandom_range(0, 3));
      in_data = 8'($urandom);
      in_bcast = 1'b0;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = 4'($urandom);
      #1;
      exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
      chk($sformatf("rnd%0d_in_ready", cyc), in_ready, exp_rdy);
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      if (in_valid && exp_rdy) begin
        q[in_sel].push_back(in_data);
        sent++;
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd%0d_valid%0d", cyc, k), out_valid[k], q[k].size() != 0);
        if (q[k].size() != 0)
          chk($sformatf("rnd%0d_data%0d", cyc, k), out_data[k*8 +: 8], q[k][0]);
      end
    end
    chk("rnd_sent_count", sent, 100);
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
    chk("rnd_final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
